ex_pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the EX stage.
- Generates PC/IF-ID write enables, pipeline flushes and the PC-select for redirects resolved in EX (branches, jal, jalr).
- Detects load-use hazards between ID and EX.
- Sequences a shared multi-cycle execution unit (mul/div) through a go/done handshake with timeout, and keeps saturating stall/flush performance counters.

---
 rtl/ex_pipe_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ex_pipe_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe_ctrl.sv
// ex_pipe_ctrl -- EX-stage pipeline sequencing controller.
//
// Purpose:
//   Drives the PC / IF-ID / ID-EX load enables and bubble flushes. It handles
//   redirects resolved in EX (taken branch, jal, jalr), load-use hazards
//   between ID and EX, and a shared multi-cycle unit (mul/div) that runs
//   through a go/done handshake with a timeout. It also keeps saturating
//   stall and flush performance counters.
//
// Handshake with the multi-cycle unit:
//   mc_go_o is a one-cycle start pulse, issued only from RUN. The unit answers
//   with a one-cycle mc_done_i pulse. No second go is issued until that done
//   arrives or the timeout abort fires. mc_abort_o is a one-cycle pulse that
//   tells the unit to drop the operation. A reset abandons the operation with
//   no abort pulse, because the unit shares rst.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   id_rs1_i/id_rs2_i   source register indices of the ID instruction
//   id_use_rs1_i/_rs2_i ID instruction actually reads rs1/rs2
//   ex_valid_i          EX holds a real instruction
//   ex_rd_i             EX destination register
//   ex_memread_i        EX instruction is a load
//   jump_flag_ex_i      EX resolved a taken branch / jal / jalr
//   pc_new_ex_i         EX-computed target PC
//   mc_req_ex_i         EX instruction needs the multi-cycle unit
//   mc_done_i           multi-cycle result valid (1-cycle pulse)
//   pc_write_o          PC load enable
//   pc_sel_o            1 = PC loads pc_redirect_o
//   pc_redirect_o       redirect target (always pc_new_ex_i)
//   if_id_write_o       IF/ID load enable
//   if_id_flush_o       IF/ID loads a bubble
//   id_ex_write_o       ID/EX load enable
//   id_ex_flush_o       ID/EX loads a bubble
//   mc_go_o             multi-cycle start pulse
//   mc_abort_o          multi-cycle timeout abort pulse
//   mc_err_o            sticky timeout error
//   stall_cnt_o         saturating count of cycles with the PC held
//   flush_cnt_o         saturating count of redirects taken
//   dbg_state_o         current FSM state (0 = RUN, 1 = MC_BUSY)

module ex_pipe_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             jump_flag_ex_i,
    input  logic [31:0]      pc_new_ex_i,
    input  logic             mc_req_ex_i,
    input  logic             mc_done_i,
    output logic             pc_write_o,
    output logic             pc_sel_o,
    output logic [31:0]      pc_redirect_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_flush_o,
    output logic             mc_go_o,
    output logic             mc_abort_o,
    output logic             mc_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             dbg_state_o
);

    // The age counter only ever needs to reach MC_TIMEOUT-1.
    localparam int            TW     = $clog2(MC_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(MC_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [TW-1:0]  mc_age;
    logic           redirect_take;
    logic           load_use;

    assign pc_redirect_o = pc_new_ex_i;
    assign dbg_state_o   = state;

    // A load to x0 never creates a real dependency.
    assign load_use = ex_valid_i && ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        pc_write_o    = 1'b1;
        pc_sel_o      = 1'b0;
        if_id_write_o = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_write_o = 1'b1;
        id_ex_flush_o = 1'b0;
        mc_go_o       = 1'b0;
        mc_abort_o    = 1'b0;
        redirect_take = 1'b0;
        state_nxt     = state;

        if (rst) begin
            // Freeze the pipeline and fill both stage registers with bubbles.
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_write_o = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_nxt     = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (ex_valid_i && jump_flag_ex_i) begin
                        // The redirect beats a load-use stall because the ID
                        // instruction is on the wrong path and gets squashed.
                        redirect_take = 1'b1;
                        pc_sel_o      = 1'b1;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (ex_valid_i && mc_req_ex_i) begin
                        mc_go_o       = 1'b1;
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_write_o = 1'b0;
                        state_nxt     = MC_BUSY;
                    end else if (load_use) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (mc_done_i) begin
                        // Release in the done cycle so ID/EX picks up the
                        // next instruction without a dead cycle.
                        state_nxt = RUN;
                    end else if (mc_age == T_LAST) begin
                        mc_abort_o = 1'b1;
                        state_nxt  = RUN;
                    end else begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_write_o = 1'b0;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            mc_age      <= '0;
            mc_err_o    <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state <= state_nxt;

            if (mc_go_o) begin
                mc_age <= '0;
            end else if (state == MC_BUSY) begin
                mc_age <= mc_age + TW'(1);
            end

            if (mc_abort_o) begin
                mc_err_o <= 1'b1;
            end

            if (!pc_write_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end

            if (redirect_take && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// tb_ex_pipe_ctrl -- bench for ex_pipe_ctrl.
// Two instances share every input: "a" has a short timeout and narrow
// counters (MC_TIMEOUT=4, CNT_W=4), "b" has MC_TIMEOUT=8 and CNT_W=16.
// A behavioural model follows each instance, and a compare process checks
// both against it on every falling edge. Directed sections add literal
// expectations.

module tb_ex_pipe_ctrl;

    localparam int TMO_A = 4;
    localparam int TMO_B = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_valid, ex_memread;
    logic        jump_flag, mc_req, mc_done;
    logic [31:0] pc_new;

    logic        pc_write_a, pc_sel_a, if_id_write_a, if_id_flush_a;
    logic        id_ex_write_a, id_ex_flush_a, mc_go_a, mc_abort_a, mc_err_a, dbg_a;
    logic [31:0] redir_a;
    logic [3:0]  stall_a, flush_a;

    logic        pc_write_b, pc_sel_b, if_id_write_b, if_id_flush_b;
    logic        id_ex_write_b, id_ex_flush_b, mc_go_b, mc_abort_b, mc_err_b, dbg_b;
    logic [31:0] redir_b;
    logic [15:0] stall_b, flush_b;

    ex_pipe_ctrl #(.MC_TIMEOUT(TMO_A), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
        .jump_flag_ex_i(jump_flag), .pc_new_ex_i(pc_new),
        .mc_req_ex_i(mc_req), .mc_done_i(mc_done),
        .pc_write_o(pc_write_a), .pc_sel_o(pc_sel_a), .pc_redirect_o(redir_a),
        .if_id_write_o(if_id_write_a), .if_id_flush_o(if_id_flush_a),
        .id_ex_write_o(id_ex_write_a), .id_ex_flush_o(id_ex_flush_a),
        .mc_go_o(mc_go_a), .mc_abort_o(mc_abort_a), .mc_err_o(mc_err_a),
        .stall_cnt_o(stall_a), .flush_cnt_o(flush_a), .dbg_state_o(dbg_a)
    );

    ex_pipe_ctrl #(.MC_TIMEOUT(TMO_B), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
        .jump_flag_ex_i(jump_flag), .pc_new_ex_i(pc_new),
        .mc_req_ex_i(mc_req), .mc_done_i(mc_done),
        .pc_write_o(pc_write_b), .pc_sel_o(pc_sel_b), .pc_redirect_o(redir_b),
        .if_id_write_o(if_id_write_b), .if_id_flush_o(if_id_flush_b),
        .id_ex_write_o(id_ex_write_b), .id_ex_flush_o(id_ex_flush_b),
        .mc_go_o(mc_go_b), .mc_abort_o(mc_abort_b), .mc_err_o(mc_err_b),
        .stall_cnt_o(stall_b), .flush_cnt_o(flush_b), .dbg_state_o(dbg_b)
    );

    // Outputs gathered per instance:
    // {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
    //  go, abort, err, state}
    logic [9:0]  act_ctrl [2];
    logic [31:0] act_cnt  [2];
    logic [31:0] act_redir[2];
    assign act_ctrl[0]  = {pc_write_a, pc_sel_a, if_id_write_a, if_id_flush_a, id_ex_write_a,
                           id_ex_flush_a, mc_go_a, mc_abort_a, mc_err_a, dbg_a};
    assign act_ctrl[1]  = {pc_write_b, pc_sel_b, if_id_write_b, if_id_flush_b, id_ex_write_b,
                           id_ex_flush_b, mc_go_b, mc_abort_b, mc_err_b, dbg_b};
    assign act_cnt[0]   = {12'd0, stall_a, 12'd0, flush_a};
    assign act_cnt[1]   = {stall_b, flush_b};
    assign act_redir[0] = redir_a;
    assign act_redir[1] = redir_b;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: busy flag, cycles spent busy, sticky error, counters.
    int tmo [2] = '{TMO_A, TMO_B};
    int cmax[2] = '{15, 65535};
    int m_busy[2], m_age[2], m_err[2], m_stall[2], m_flush[2];
    logic [9:0] exp_q[$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_age[i] = 0; m_err[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
    end

    bit e_pcw, e_sel, e_ifw, e_iff, e_idw, e_idf, e_go, e_ab;
    bit redirect, start, hazard, finish;

    // Expected outputs come from the model state before this cycle's edge;
    // the model then moves to its post-edge state.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            redirect = 0; start = 0; hazard = 0; finish = 0;
            e_pcw = 1; e_sel = 0; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_go = 0; e_ab = 0;
            if (rst) begin
                e_pcw = 0; e_ifw = 0; e_idw = 0; e_iff = 1; e_idf = 1;
            end else if (m_busy[i] == 0) begin
                redirect = ex_valid && jump_flag;
                start    = ex_valid && mc_req && !redirect;
                hazard   = ex_valid && ex_memread && (ex_rd != 0) && !redirect && !start &&
                           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
                e_pcw = !(start || hazard);
                e_ifw = !(start || hazard);
                e_idw = !start;
                e_sel = redirect;
                e_iff = redirect;
                e_idf = redirect || hazard;
                e_go  = start;
            end else begin
                finish = mc_done || (m_age[i] == tmo[i] - 1);
                e_ab   = !mc_done && (m_age[i] == tmo[i] - 1);
                e_pcw = finish; e_ifw = finish; e_idw = finish;
            end

            exp_q.push_back({e_pcw, e_sel, e_ifw, e_iff, e_idw, e_idf, e_go, e_ab,
                             m_err[i] != 0, m_busy[i] != 0});
            n_checks++;
            if (act_ctrl[i] === exp_q[0]) n_pass++;
            else $display("FAIL ctrl[%0d] t=%0t: got %b, expected %b", i, $time, act_ctrl[i], exp_q[0]);
            void'(exp_q.pop_front());

            n_checks++;
            if (act_cnt[i] === {16'(m_stall[i]), 16'(m_flush[i])}) n_pass++;
            else $display("FAIL cnt[%0d] t=%0t: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                          i, $time, act_cnt[i][31:16], act_cnt[i][15:0], m_stall[i], m_flush[i]);

            n_checks++;
            if (act_redir[i] === pc_new) n_pass++;
            else $display("FAIL redirect[%0d]: got %h, expected %h", i, act_redir[i], pc_new);

            if (rst) begin
                m_busy[i] = 0; m_age[i] = 0; m_err[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                if (!e_pcw && m_stall[i] < cmax[i]) m_stall[i]++;
                if (redirect && m_flush[i] < cmax[i]) m_flush[i]++;
                if (e_ab) m_err[i] = 1;
                if (start) begin
                    m_busy[i] = 1; m_age[i] = 0;
                end else if (m_busy[i] != 0) begin
                    if (finish) m_busy[i] = 0;
                    else m_age[i]++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_memread = 0; jump_flag = 0;
        pc_new = 32'h0; mc_req = 0; mc_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic start_mc();
        idle();
        ex_valid = 1;
        mc_req   = 1;
    endtask

    int go_seen;

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1;
        idle();
        tick();
        tick();
        tick();
        #1;
        chk("reset_pc_write", pc_write_a, 0);
        chk("reset_if_id_flush", if_id_flush_b, 1);
        rst = 0;
        #1;
        chk("post_reset_pc_write", pc_write_a, 1);
        chk("post_reset_stall", stall_b, 0);
        chk("post_reset_err", mc_err_a, 0);

        // Reset lands while the multi-cycle unit is busy.
        tick();
        start_mc();
        tick();
        idle();
        tick();
        rst = 1;
        #1;
        chk("rst_busy_abort", mc_abort_a, 0);
        tick();
        tick();
        rst = 0;
        #1;
        chk("rst_busy_state", dbg_b, 0);
        chk("rst_busy_stall", stall_b, 0);
        chk("rst_busy_pc_write", pc_write_b, 1);

        // Load-use on x5 through rs2.
        tick();
        ex_valid = 1; ex_memread = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
        #1;
        chk("lu_pc_write", pc_write_a, 0);
        chk("lu_if_id_write", if_id_write_a, 0);
        chk("lu_id_ex_flush", id_ex_flush_b, 1);
        tick();
        idle();
        #1;
        chk("lu_release", pc_write_a, 1);
        chk("lu_stall_cnt", stall_b, 1);

        // The same pattern on x0 is not a hazard.
        ex_valid = 1; ex_memread = 1; ex_rd = 0; id_use_rs2 = 1; id_rs2 = 0;
        #1;
        chk("lu_x0_no_stall", pc_write_b, 1);
        tick();
        idle();

        // Redirect wins over a simultaneous load-use match.
        ex_valid = 1; ex_memread = 1; ex_rd = 7; id_use_rs1 = 1; id_rs1 = 7;
        jump_flag = 1; pc_new = 32'h0000_0100;
        #1;
        chk("redir_sel", pc_sel_a, 1);
        chk("redir_target", redir_a, 32'h100);
        chk("redir_if_id_flush", if_id_flush_a, 1);
        chk("redir_id_ex_flush", id_ex_flush_a, 1);
        chk("redir_no_stall", pc_write_a, 1);
        tick();
        idle();
        #1;
        chk("redir_flush_cnt", flush_b, 1);
        chk("redir_stall_cnt", stall_b, 1);

        // Done arrives in the last allowed cycle of instance a: done wins.
        do_reset();
        start_mc();
        #1;
        chk("tie_go", mc_go_a, 1);
        tick();
        idle();
        tick();
        tick();
        tick();
        mc_done = 1;
        #1;
        chk("tie_no_abort", mc_abort_a, 0);
        chk("tie_release", pc_write_a, 1);
        tick();
        idle();
        #1;
        chk("tie_no_err", mc_err_a, 0);
        chk("tie_state_run", dbg_a, 0);

        // Timeout with no done at all.
        do_reset();
        start_mc();
        tick();
        idle();
        tick();
        tick();
        tick();
        #1;
        chk("tmo_abort_a", mc_abort_a, 1);
        chk("tmo_release_a", pc_write_a, 1);
        chk("tmo_hold_b", pc_write_b, 0);
        tick();
        #1;
        chk("tmo_err_a", mc_err_a, 1);
        chk("tmo_state_a", dbg_a, 0);
        chk("tmo_abort_once", mc_abort_a, 0);
        tick();
        tick();
        tick();
        #1;
        chk("tmo_abort_b", mc_abort_b, 1);
        tick();
        tick();
        #1;
        chk("tmo_err_b", mc_err_b, 1);
        chk("tmo_err_sticky_a", mc_err_a, 1);

        // Done pulsed 5 cycles after go.
        do_reset();
        go_seen = 0;
        start_mc();
        #1;
        go_seen += int'(mc_go_b);
        tick();
        idle();
        for (int k = 1; k < 5; k++) begin
            #1;
            go_seen += int'(mc_go_b);
            chk("mc_hold_b", pc_write_b, 0);
            tick();
        end
        mc_done = 1;
        #1;
        go_seen += int'(mc_go_b);
        chk("mc_done_release", id_ex_write_b, 1);
        tick();
        idle();
        #1;
        chk("mc_go_count", go_seen, 1);
        chk("mc_stall_b", stall_b, 5);
        chk("mc_stall_a", stall_a, 4);

        // Twenty redirects saturate the 4-bit flush counter.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            ex_valid = 1; jump_flag = 1; pc_new = $urandom;
            tick();
        end
        idle();
        #1;
        chk("sat_flush_a", flush_a, 15);
        chk("sat_flush_b", flush_b, 20);

        // Random traffic; the compare process does the checking.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 79) == 0);
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_rd      = 5'($urandom_range(0, 3));
            ex_memread = 1'($urandom_range(0, 1));
            jump_flag  = ($urandom_range(0, 5) == 0);
            mc_req     = ($urandom_range(0, 7) == 0);
            mc_done    = ($urandom_range(0, 5) == 0);
            pc_new     = $urandom;
            tick();
        end
        idle();
        rst = 0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
